// File: rtl/uart_tx_arbiter_pkg.sv
// uart_tx_arbiter_pkg
//   Shared constants for the UART TX arbiter slice: ASCII codes used for the
//   idle data value and the CR/LF packet suffix, the FSM state encoding, and
//   the internal sum width used by the round-robin picker.
package uart_tx_arbiter_pkg;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_SP = 8'h20;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PASS    = 2'd1;
  localparam logic [1:0] ST_SEND_CR = 2'd2;
  localparam logic [1:0] ST_SEND_LF = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE    = ST_IDLE,
    S_PASS    = ST_PASS,
    S_SEND_CR = ST_SEND_CR,
    S_SEND_LF = ST_SEND_LF
  } state_t;

  // last_grant + offset stays below 2*NUM_SRC <= 16, so 5 bits always suffice.
  localparam int RR_SUM_W = 5;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// uart_tx_arbiter_rr_pick
//   Combinational round-robin picker. Scans the request vector starting at
//   last_grant+1 (wrapping modulo NUM_SRC) and returns the first requester.
// Ports:
//   req        in  NUM_SRC  request vector
//   last_grant in  ID_W     most recently granted index (lowest priority)
//   valid      out 1        at least one request present
//   idx        out ID_W     selected index (0 when valid is low)
module uart_tx_arbiter_rr_pick
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_SRC = 2,
  parameter int ID_W    = 1
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [ID_W-1:0]    last_grant,
  output logic               valid,
  output logic [ID_W-1:0]    idx
);

  localparam int SW = RR_SUM_W;

  // cand[k] is the index examined at priority position k (k=0 is highest).
  logic [SW-1:0] cand [NUM_SRC];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_cand
      logic [SW-1:0] sum;
      assign sum       = SW'(last_grant) + SW'(gi + 1);
      assign cand[gi]  = (sum >= SW'(NUM_SRC)) ? (sum - SW'(NUM_SRC)) : sum;
    end
  endgenerate

  // Walk priority positions from lowest to highest so the highest-priority
  // hit is the one left standing.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      for (int j = 0; j < NUM_SRC; j++) begin
        if (req[j] && (cand[k] == SW'(j))) begin
          valid = 1'b1;
          idx   = ID_W'(j);
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Packet-level round-robin arbiter sharing one UART TX write port between
//   NUM_SRC byte sources. Locks onto one source for a full packet, then
//   optionally appends CR LF before re-arbitrating.
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   src_valid/data/last per-source byte stream (data at [8*i+7:8*i])
//   src_ready           per-source accept (valid & ready transfers a byte)
//   tx_full             UART TX FIFO full
//   wr_uart, w_data     one-cycle write strobe and byte to the UART
//   busy                registered, high in any state other than IDLE
//   grant_id            registered index of the current/most recent grant
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_SRC     = 2,
  parameter bit APPEND_CRLF = 1'b1,
  parameter int ID_W        = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_SRC-1:0]   src_valid,
  input  logic [8*NUM_SRC-1:0] src_data,
  input  logic [NUM_SRC-1:0]   src_last,
  output logic [NUM_SRC-1:0]   src_ready,
  input  logic                 tx_full,
  output logic                 wr_uart,
  output logic [7:0]           w_data,
  output logic                 busy,
  output logic [ID_W-1:0]      grant_id
);

  state_t            state_reg, state_next;
  logic [ID_W-1:0]   grant_id_reg, grant_id_next;
  logic [ID_W-1:0]   last_grant_reg, last_grant_next;
  logic              busy_reg;

  logic              pick_valid;
  logic [ID_W-1:0]   pick_idx;

  logic [NUM_SRC-1:0] grant_hot;
  logic [7:0]         data_arr [NUM_SRC];
  logic [7:0]         sel_data;
  logic               sel_valid;
  logic               sel_last;

  uart_tx_arbiter_rr_pick #(
    .NUM_SRC (NUM_SRC),
    .ID_W    (ID_W)
  ) u_rr_pick (
    .req        (src_valid),
    .last_grant (last_grant_reg),
    .valid      (pick_valid),
    .idx        (pick_idx)
  );

  // One-hot decode of the registered grant; drives the data/valid/last mux
  // without a variable-width index into the source buses.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
      assign grant_hot[gi] = (grant_id_reg == ID_W'(gi));
      assign data_arr[gi]  = src_data[8*gi +: 8];
    end
  endgenerate

  assign sel_valid = |(grant_hot & src_valid);
  assign sel_last  = |(grant_hot & src_last);

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      sel_data = sel_data | (data_arr[i] & {8{grant_hot[i]}});
    end
  end

  // State and grant registers. busy follows the next state so it is high on
  // exactly the cycles the FSM sits outside IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= S_IDLE;
      grant_id_reg   <= '0;
      last_grant_reg <= ID_W'(NUM_SRC - 1);
      busy_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      grant_id_reg   <= grant_id_next;
      last_grant_reg <= last_grant_next;
      busy_reg       <= (state_next != S_IDLE);
    end
  end

  // Next-state logic.
  always_comb begin
    state_next      = state_reg;
    grant_id_next   = grant_id_reg;
    last_grant_next = last_grant_reg;
    case (state_reg)
      S_IDLE: begin
        if (pick_valid) begin
          grant_id_next   = pick_idx;
          last_grant_next = pick_idx;
          state_next      = S_PASS;
        end
      end
      S_PASS: begin
        // The lock holds through valid gaps; only an accepted last byte exits.
        if (sel_valid && !tx_full && sel_last) begin
          state_next = APPEND_CRLF ? S_SEND_CR : S_IDLE;
        end
      end
      S_SEND_CR: if (!tx_full) state_next = S_SEND_LF;
      S_SEND_LF: if (!tx_full) state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    wr_uart   = 1'b0;
    src_ready = '0;
    w_data    = ASCII_SP;
    case (state_reg)
      S_PASS: begin
        src_ready = grant_hot & {NUM_SRC{~tx_full}};
        wr_uart   = sel_valid & ~tx_full;
        w_data    = sel_data;
      end
      S_SEND_CR: begin
        wr_uart = ~tx_full;
        w_data  = ASCII_CR;
      end
      S_SEND_LF: begin
        wr_uart = ~tx_full;
        w_data  = ASCII_LF;
      end
      default: ;
    endcase
  end

  assign busy     = busy_reg;
  assign grant_id = grant_id_reg;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
//   Self-checking bench. Main instance: NUM_SRC=2 with CR/LF suffix; second
//   instance: NUM_SRC=2 without suffix. Sources are byte FIFOs in the bench;
//   the expected UART byte stream is built from the round-robin packet rule.
module tb_uart_tx_arbiter;

  localparam int N = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [N-1:0]   src_valid, src_last, src_ready;
  logic [8*N-1:0] src_data;
  logic           tx_full, wr_uart, busy;
  logic [7:0]     w_data;
  logic [0:0]     grant_id;

  logic [N-1:0]   src_valid_b, src_last_b, src_ready_b;
  logic [8*N-1:0] src_data_b;
  logic           tx_full_b, wr_uart_b, busy_b;
  logic [7:0]     w_data_b;
  logic [0:0]     grant_id_b;

  uart_tx_arbiter #(.NUM_SRC(N), .APPEND_CRLF(1'b1), .ID_W(1)) dut (
    .clk(clk), .reset(reset), .src_valid(src_valid), .src_data(src_data),
    .src_last(src_last), .src_ready(src_ready), .tx_full(tx_full),
    .wr_uart(wr_uart), .w_data(w_data), .busy(busy), .grant_id(grant_id)
  );

  uart_tx_arbiter #(.NUM_SRC(N), .APPEND_CRLF(1'b0), .ID_W(1)) dut_b (
    .clk(clk), .reset(reset), .src_valid(src_valid_b), .src_data(src_data_b),
    .src_last(src_last_b), .src_ready(src_ready_b), .tx_full(tx_full_b),
    .wr_uart(wr_uart_b), .w_data(w_data_b), .busy(busy_b), .grant_id(grant_id_b)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // Per-source byte FIFOs with packet markers.
  logic [7:0] sbuf   [N][256];
  bit         slast  [N][256];
  bit         sfirst [N][256];
  int         shead  [N];
  int         stail  [N];

  // Observed UART writes and expected stream.
  logic [7:0] obs     [512];
  int         obs_cyc [512];
  int         obs_gid [512];
  int         nobs;
  logic [7:0] expb    [512];
  int         nexp;

  bit   gaps, rand_full, force_full;
  logic busy_s;
  int   gid_s;

  bit         b_valid, b_last;
  logic [7:0] b_data;
  int         b_nwr, b_wcyc;
  logic [7:0] b_wdata;
  logic       b_busy_s;

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, o, e);
    end
  endtask

  task automatic push_byte(input int s, input logic [7:0] b, input bit f, input bit l);
    sbuf[s][stail[s]]   = b;
    sfirst[s][stail[s]] = f;
    slast[s][stail[s]]  = l;
    stail[s]++;
  endtask

  task automatic push_rand_pkt(input int s, input int len);
    for (int k = 0; k < len; k++)
      push_byte(s, 8'($urandom_range(0, 255)), k == 0, k == len - 1);
  endtask

  // Reference: whole packets leave in round-robin order among sources that
  // still hold packets, each followed by CR LF.
  task automatic build_exp(input int start_last);
    int  p [N];
    int  last, s;
    bit  found, done;
    for (int i = 0; i < N; i++) p[i] = shead[i];
    nexp = 0;
    last = start_last;
    found = 1'b1;
    while (found) begin
      found = 1'b0;
      for (int k = 1; k <= N && !found; k++) begin
        s = (last + k) % N;
        if (p[s] != stail[s]) begin
          done = 1'b0;
          while (!done) begin
            expb[nexp] = sbuf[s][p[s]];
            nexp++;
            done = slast[s][p[s]];
            p[s]++;
          end
          expb[nexp] = 8'h0D; nexp++;
          expb[nexp] = 8'h0A; nexp++;
          last  = s;
          found = 1'b1;
        end
      end
    end
  endtask

  task automatic check_stream(input string tag);
    int m;
    chk({tag, "_count"}, nobs, nexp);
    m = (nobs < nexp) ? nobs : nexp;
    for (int k = 0; k < m; k++)
      chk($sformatf("%s_byte[%0d]", tag, k), obs[k], expb[k]);
  endtask

  // One clock: drive at negedge, sample 1ns later, transfer at posedge.
  task automatic cycle();
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (shead[i] != stail[i]) begin
        src_valid[i]      = sfirst[i][shead[i]] || !gaps || ($urandom_range(0, 3) != 0);
        src_data[8*i +: 8] = sbuf[i][shead[i]];
        src_last[i]       = slast[i][shead[i]];
      end else begin
        src_valid[i]      = 1'b0;
        src_data[8*i +: 8] = 8'h00;
        src_last[i]       = 1'b0;
      end
    end
    tx_full     = force_full || (rand_full && ($urandom_range(0, 2) == 0));
    src_valid_b = {1'b0, b_valid};
    src_data_b  = {8'h00, b_data};
    src_last_b  = {1'b0, b_last};
    tx_full_b   = 1'b0;
    #1;
    if (tx_full) begin
      chk("wr_while_full", wr_uart, 0);
      chk("ready_while_full", src_ready, 0);
    end
    if (wr_uart && nobs < 512) begin
      obs[nobs]     = w_data;
      obs_cyc[nobs] = cyc;
      obs_gid[nobs] = int'(grant_id);
      chk("busy_on_write", busy, 1);
      nobs++;
    end
    for (int i = 0; i < N; i++) begin
      if (src_valid[i] && src_ready[i]) begin
        chk("accept_wr", wr_uart, 1);
        chk("accept_data", w_data, sbuf[i][shead[i]]);
        shead[i]++;
      end
    end
    if (wr_uart_b) begin
      b_nwr++;
      b_wdata = w_data_b;
      b_wcyc  = cyc;
    end
    busy_s   = busy;
    b_busy_s = busy_b;
    gid_s    = int'(grant_id);
    cyc++;
  endtask

  task automatic drain(input int max_cyc);
    int n, pend;
    n = 0;
    while (((shead[0] != stail[0]) || (shead[1] != stail[1]) || busy_s) && n < max_cyc) begin
      cycle();
      n++;
    end
    pend = (stail[0] - shead[0]) + (stail[1] - shead[1]) + int'(busy_s);
    chk("drain_done", pend, 0);
  endtask

  task automatic clear_queues();
    for (int i = 0; i < N; i++) begin
      shead[i] = 0;
      stail[i] = 0;
    end
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    force_full = 1'b0;
    rand_full  = 1'b0;
    gaps       = 1'b0;
    b_valid    = 1'b0;
    b_last     = 1'b0;
    b_data     = 8'h00;
    clear_queues();
    cycle();
    cycle();
    reset = 1'b0;
    nobs  = 0;
    b_nwr = 0;
  endtask

  initial begin
    int base;

    // Reset state
    do_reset();
    chk("rst_busy", busy, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_wr_uart", wr_uart, 0);
    chk("rst_src_ready", src_ready, 0);
    chk("rst_w_data", w_data, 8'h20);
    chk("rst_busy_b", busy_b, 0);
    $display("reset state checked");

    // Source 0 sends "4B": 4 consecutive writes starting 1 cycle after valid
    do_reset();
    push_byte(0, 8'h34, 1, 0);
    push_byte(0, 8'h42, 0, 1);
    build_exp(N - 1);
    base = cyc;
    repeat (6) cycle();
    check_stream("t1");
    for (int k = 0; k < 4 && k < nobs; k++)
      chk($sformatf("t1_cycle[%0d]", k), obs_cyc[k], base + 1 + k);
    chk("t1_busy_after_lf", busy_s, 0);
    $display("packet 4B: %0d writes", nobs);

    // Two simultaneous 3-byte packets right after reset
    do_reset();
    push_rand_pkt(0, 3);
    push_rand_pkt(1, 3);
    build_exp(N - 1);
    drain(200);
    check_stream("t2");
    for (int k = 0; k < 10 && k < nobs; k++)
      chk($sformatf("t2_gid[%0d]", k), obs_gid[k], (k < 5) ? 0 : 1);
    $display("simultaneous requests: %0d writes", nobs);

    // Source 1 continuously valid, source 0 repeatedly requesting
    do_reset();
    for (int p = 0; p < 3; p++) begin
      push_byte(0, 8'(8'h30 + p), 1, 0);
      push_byte(0, 8'(8'h38 + p), 0, 1);
      push_byte(1, 8'(8'h60 + p), 1, 0);
      push_byte(1, 8'(8'h68 + p), 0, 1);
    end
    build_exp(N - 1);
    drain(300);
    check_stream("t3");
    for (int p = 0; p < 6; p++)
      if (4 * p < nobs) chk($sformatf("t3_pkt_gid[%0d]", p), obs_gid[4 * p], p % 2);
    $display("alternating grants: %0d writes", nobs);

    // tx_full held 5 cycles mid-packet and 2 cycles during SEND_CR
    do_reset();
    push_byte(0, 8'h58, 1, 0);
    push_byte(0, 8'h59, 0, 0);
    push_byte(0, 8'h5A, 0, 1);
    build_exp(N - 1);
    base = cyc;
    cycle();
    cycle();
    force_full = 1'b1;
    repeat (5) cycle();
    force_full = 1'b0;
    cycle();
    cycle();
    force_full = 1'b1;
    repeat (2) cycle();
    force_full = 1'b0;
    repeat (3) cycle();
    check_stream("t4");
    if (nobs > 1) chk("t4_y_cycle", obs_cyc[1], base + 7);
    if (nobs > 3) chk("t4_cr_cycle", obs_cyc[3], base + 11);
    chk("t4_busy_end", busy_s, 0);
    $display("tx_full stall: %0d writes", nobs);

    // No-suffix instance: single-byte packet 0x41
    do_reset();
    base    = cyc;
    b_valid = 1'b1;
    b_data  = 8'h41;
    b_last  = 1'b1;
    cycle();
    cycle();
    b_valid = 1'b0;
    b_last  = 1'b0;
    cycle();
    cycle();
    chk("t5_write_count", b_nwr, 1);
    chk("t5_write_data", b_wdata, 8'h41);
    chk("t5_write_cycle", b_wcyc, base + 1);
    chk("t5_busy_end", b_busy_s, 0);
    $display("no-suffix single byte: %0d writes", b_nwr);

    // Reset after 1 of 3 bytes; partial packet abandoned
    do_reset();
    push_byte(0, 8'h61, 1, 0);
    push_byte(0, 8'h62, 0, 0);
    push_byte(0, 8'h63, 0, 1);
    push_byte(1, 8'h70, 1, 0);
    push_byte(1, 8'h71, 0, 1);
    cycle();
    cycle();
    clear_queues();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    cycle();
    chk("t6_busy_after_reset", busy_s, 0);
    chk("t6_gid_after_reset", gid_s, 0);
    chk("t6_writes_before_reset", nobs, 1);
    nobs = 0;
    push_byte(0, 8'h61, 1, 0);
    push_byte(0, 8'h62, 0, 0);
    push_byte(0, 8'h63, 0, 1);
    push_byte(1, 8'h70, 1, 0);
    push_byte(1, 8'h71, 0, 1);
    build_exp(N - 1);
    drain(200);
    check_stream("t6");
    $display("reset mid-packet: %0d writes after restart", nobs);

    // Randomized rounds with valid gaps and random back-pressure
    for (int r = 0; r < 4; r++) begin
      do_reset();
      gaps      = 1'b1;
      rand_full = 1'b1;
      for (int s = 0; s < N; s++) begin
        int np;
        np = $urandom_range(1, 3);
        for (int p = 0; p < np; p++) push_rand_pkt(s, $urandom_range(1, 5));
      end
      build_exp(N - 1);
      drain(2000);
      check_stream($sformatf("rnd%0d", r));
      $display("random round %0d: %0d writes, %0d expected", r, nobs, nexp);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Packet-level round-robin arbiter that shares the single UART transmitter write port (wr_uart / w_data / tx_full) between several ASCII message sources, such as keyboard and mouse monitors. Each source streams bytes with a valid/ready/last handshake. The arbiter locks onto one source for a whole packet, so messages never interleave. After each packet it optionally appends CR LF. It sits between the monitor FSMs and the uart instance.

Parameters:
NUM_SRC, 2, number of requesting sources (2..8)
APPEND_CRLF, 1, 1 = send 0x0D then 0x0A after each packet's last byte; 0 = no suffix
ID_W, 1, width of grant_id; must satisfy 2**ID_W >= NUM_SRC

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
src_valid  in  NUM_SRC  source i presents a byte
src_data  in  8*NUM_SRC  byte of source i at bits [8*i+7:8*i]
src_last  in  NUM_SRC  byte of source i is the final byte of its packet
src_ready  out  NUM_SRC  byte of source i is accepted this cycle when valid & ready
tx_full  in  1  UART TX FIFO full
wr_uart  out  1  one-cycle write strobe to the UART
w_data  out  8  byte to the UART
busy  out  1  registered; 1 while any state other than IDLE
grant_id  out  ID_W  registered; index of the current or most recent grant

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high: reset is sampled only on the rising edge of clk.
- States: IDLE, PASS, SEND_CR, SEND_LF.
- Reset values: state=IDLE, last_grant=NUM_SRC-1 (so source 0 wins first), grant_id=0, busy=0. Combinational outputs in IDLE: wr_uart=0, src_ready=0, w_data=0x20.
- IDLE:
  - If any src_valid is high, pick the first asserted index scanning from last_grant+1, modulo NUM_SRC.
  - Register it into grant_id and last_grant, then go to PASS.
  - No byte is transferred in IDLE, so arbitration costs one cycle.
- PASS, with g = grant_id:
  - src_ready[g] = ~tx_full. All other src_ready bits are 0.
  - wr_uart = src_valid[g] & ~tx_full. w_data = src_data[g].
  - A byte is accepted when src_valid[g] & ~tx_full.
  - If the accepted byte has src_last[g] set: go to SEND_CR when APPEND_CRLF=1, else go to IDLE.
  - Otherwise stay in PASS. The lock holds even while src_valid[g] is low; other sources wait.
- SEND_CR: w_data=0x0D, wr_uart=~tx_full. Advance to SEND_LF on the cycle the write occurs.
- SEND_LF: w_data=0x0A, wr_uart=~tx_full. Advance to IDLE on the cycle the write occurs.
- Throughput: one byte per cycle while tx_full=0. Latency from first src_valid in IDLE to the first wr_uart is 1 cycle.
- wr_uart is never asserted while tx_full=1. No byte is dropped or duplicated.
- Round-robin rule: the source granted last has the lowest priority at the next arbitration. A source that holds valid continuously cannot starve the others.
- Simultaneous requests in IDLE: exactly one grant is made, per the rotation.
- A single-byte packet (valid and last together) is legal: PASS lasts 1 cycle, then CR/LF.
- Reset mid-packet: the FSM returns to IDLE on the next edge and the partial packet is abandoned. CR/LF is not sent; the source must restart its packet.
- Invalid grant index (NUM_SRC not a power of 2): unreachable by construction.

Decomposition:
- Shared package/header: the ASCII constants CR=8'h0D, LF=8'h0A, SP=8'h20, and the state encoding localparams.
- One sub-module: rr_pick. It is combinational and takes the request vector and last_grant, and returns a valid flag and an index.
- The top level holds the FSM, the grant registers and the output muxing.

Test Plan:
- Source 0 sends "4B" with last on 'B', tx_full=0, APPEND_CRLF=1 -> wr_uart pulses with 0x34, 0x42, 0x0D, 0x0A on 4 consecutive cycles, starting 1 cycle after valid; busy falls after LF.
- Sources 0 and 1 both request 3-byte packets at the same cycle right after reset -> source 0's 3 bytes + CR LF go out first, then source 1's; grant_id goes 0 then 1; no interleaving.
- Source 1 holds valid continuously while source 0 requests repeatedly -> grants alternate 0,1,0,1.
- tx_full is held high for 5 cycles mid-packet -> wr_uart=0 and src_ready=0 for those 5 cycles; the byte presented is written exactly once after tx_full falls; tx_full high during SEND_CR delays the 0x0D write.
- APPEND_CRLF=0 with a single-byte packet 0x41 -> exactly one write of 0x41, then IDLE.
- reset asserted in PASS after 1 of 3 bytes -> next cycle state=IDLE, busy=0, no CR/LF emitted; the next grant goes to source 0.
